// File: rtl/neuron_acc.sv
// Accumulates N_TERMS sign-magnitude products plus a bias into one saturated sign-magnitude result.
// Build option: define NEURON_ACC_RELU_EN to fuse a ReLU into the output conversion.
module neuron_acc #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_bias,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [15:0] i_in_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_out_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  localparam logic [7:0]              LP_N_TERMS = 8'(N_TERMS);
  localparam logic signed [ACC_W-1:0] LP_POS_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] LP_NEG_MAX = ACC_W'(-32767);

  state_e                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_cnt;
  logic [15:0]             r_out_data;
  logic                    r_out_valid;
  logic                    r_in_ready;
  logic                    r_busy;

  logic signed [ACC_W-1:0] w_acc_base;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [7:0]              w_cnt_next;
  logic                    w_last;
  logic                    w_accept;
  logic [14:0]             w_mag;
  logic [15:0]             w_sat;

  // Negative zero (8000) maps to 0 because its magnitude field is zero.
  function automatic logic signed [ACC_W-1:0] f_conv(input logic [15:0] x);
    logic signed [ACC_W-1:0] mag;
    mag = {{(ACC_W-15){1'b0}}, x[14:0]};
    return x[15] ? -mag : mag;
  endfunction

  assign w_accept   = i_in_valid && r_in_ready;
  assign w_acc_base = (r_state == ST_IDLE) ? f_conv(i_bias) : r_acc;
  assign w_acc_next = w_acc_base + f_conv(i_in_data);
  assign w_cnt_next = (r_state == ST_IDLE) ? 8'd1 : r_cnt + 8'd1;
  assign w_last     = (w_cnt_next == LP_N_TERMS);
  assign w_mag      = w_acc_next[ACC_W-1] ? (15'd0 - w_acc_next[14:0]) : w_acc_next[14:0];

  // Saturated conversion of the sum that the current accept would produce.
  always_comb begin
    w_sat = {1'b0, w_mag};
    if (w_acc_next > LP_POS_MAX) begin
      w_sat = 16'h7FFF;
    end else if (w_acc_next[ACC_W-1]) begin
`ifdef NEURON_ACC_RELU_EN
      w_sat = 16'h0000;
`else
      w_sat = (w_acc_next < LP_NEG_MAX) ? 16'hFFFF : {1'b1, w_mag};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= 16'h0000;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            r_acc  <= w_acc_next;
            r_cnt  <= w_cnt_next;
            r_busy <= 1'b1;
            if (w_last) begin
              r_state     <= ST_OUTPUT;
              r_out_data  <= w_sat;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_OUTPUT: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_neuron_acc.sv
// Directed and randomized checks of neuron_acc against an integer-arithmetic reference model.
module tb_neuron_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] b4 = '0, d4 = '0, od4;
  logic        v4 = 1'b0, or4 = 1'b0, rdy4, ov4, busy4;
  logic [15:0] b1 = '0, d1 = '0, od1;
  logic        v1 = 1'b0, or1 = 1'b0, rdy1, ov1, busy1;

  int vectors = 0;
  int miscompares = 0;

`ifdef NEURON_ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  always #5 clk = ~clk;

  neuron_acc #(.N_TERMS(4), .ACC_W(24)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_bias(b4), .i_in_valid(v4), .o_in_ready(rdy4),
    .i_in_data(d4), .o_out_valid(ov4), .i_out_ready(or4), .o_out_data(od4), .o_busy(busy4)
  );

  neuron_acc #(.N_TERMS(1), .ACC_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_bias(b1), .i_in_valid(v1), .o_in_ready(rdy1),
    .i_in_data(d1), .o_out_valid(ov1), .i_out_ready(or1), .o_out_data(od1), .o_busy(busy1)
  );

  // Reference model: real signed integers, saturation applied once to the final sum.
  function automatic int sm2i(input logic [15:0] x);
    int m;
    m = int'(x[14:0]);
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] ref_out(input int s);
    int a;
    if (s > 32767) return 16'h7FFF;
    if (s < 0 && RELU) return 16'h0000;
    if (s < -32767) return 16'hFFFF;
    a = (s < 0) ? -s : s;
    return {(s < 0), a[14:0]};
  endfunction

  function automatic logic [15:0] rnd_sm();
    logic [14:0] m;
    logic        sg;
    sg = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: m = 15'h7000 + 15'($urandom_range(0, 4095));
      1: m = 15'd0;
      default: m = 15'($urandom_range(0, 1023));
    endcase
    return {sg, m};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic put(input logic [15:0] d, input logic [15:0] b, input int gaps);
    int wc;
    for (int g = 0; g < gaps; g++) begin
      v4 = 1'b0;
      @(negedge clk);
    end
    v4 = 1'b1; d4 = d; b4 = b; wc = 0;
    while (!rdy4 && wc < 50) begin
      @(negedge clk);
      wc++;
    end
    check("in_ready_wait", 16'(wc < 50), 16'd1);
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic run_neuron(input logic [15:0] b, input logic [15:0] t[4], input int maxgap,
                            input int maxhold, input string tag, output logic [15:0] got);
    logic [15:0] exp;
    int hold;
    exp = ref_out(sm2i(b) + sm2i(t[0]) + sm2i(t[1]) + sm2i(t[2]) + sm2i(t[3]));
    for (int i = 0; i < 4; i++) begin
      put(t[i], b, int'($urandom_range(0, maxgap)));
      if (i < 3) check({tag, "_early_valid"}, 16'(ov4), 16'd0);
      if (i == 0) check({tag, "_busy"}, 16'(busy4), 16'd1);
    end
    check({tag, "_valid"}, 16'(ov4), 16'd1);
    check({tag, "_data"}, od4, exp);
    check({tag, "_ready_low"}, 16'(rdy4), 16'd0);
    got = od4;
    hold = int'($urandom_range(0, maxhold));
    for (int h = 0; h < hold; h++) begin
      v4 = 1'($urandom_range(0, 1)); d4 = rnd_sm(); b4 = rnd_sm();
      @(negedge clk);
      check({tag, "_hold_data"}, od4, exp);
      check({tag, "_hold_valid"}, 16'(ov4), 16'd1);
    end
    v4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    check({tag, "_drop_valid"}, 16'(ov4), 16'd0);
    check({tag, "_idle_busy"}, 16'(busy4), 16'd0);
    check({tag, "_idle_ready"}, 16'(rdy4), 16'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t [4];
    logic [15:0] got, bb;

    repeat (3) @(negedge clk);
    check("rst_valid", 16'(ov4), 16'd0);
    check("rst_data", od4, 16'h0000);
    check("rst_busy", 16'(busy4), 16'd0);
    check("rst_ready", 16'(rdy4), 16'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sum
    t = '{16'h0200, 16'h8080, 16'h0040, 16'h0000};
    run_neuron(16'h0100, t, 0, 0, "basic", got);
    check("basic_const", got, 16'h02C0);

    // Saturation both ways
    t = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    run_neuron(16'h7F00, t, 0, 1, "sat_pos", got);
    check("sat_pos_const", got, 16'h7FFF);
    t = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    run_neuron(16'hFF00, t, 0, 1, "sat_neg", got);
    check("sat_neg_const", got, RELU ? 16'h0000 : 16'hFFFF);

    // Zero handling: never negative zero
    t = '{16'h8100, 16'h8000, 16'h0000, 16'h0000};
    run_neuron(16'h0100, t, 0, 0, "zero", got);
    check("zero_const", got, 16'h0000);

    // Backpressure with junk offered during the stall
    put(16'h0200, 16'h0100, 0); put(16'h8080, 16'h0100, 0);
    put(16'h0040, 16'h0100, 0); put(16'h0000, 16'h0100, 0);
    v4 = 1'b1; d4 = 16'h7F00; b4 = 16'h7F00;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("bp_valid", 16'(ov4), 16'd1);
      check("bp_data", od4, 16'h02C0);
      check("bp_ready", 16'(rdy4), 16'd0);
    end
    d4 = 16'h0200; b4 = 16'h0100; or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    check("bp_release_valid", 16'(ov4), 16'd0);
    check("bp_release_ready", 16'(rdy4), 16'd1);
    @(negedge clk);
    v4 = 1'b0;
    check("bp_next_accept", 16'(busy4), 16'd1);
    put(16'h8080, 16'h7F00, 0); put(16'h0040, 16'h7F00, 0); put(16'h0000, 16'h7F00, 0);
    check("bp_next_valid", 16'(ov4), 16'd1);
    check("bp_next_data", od4, 16'h02C0);
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;

    // Asynchronous reset mid-neuron
    put(16'h7F00, 16'h0500, 0); put(16'h0300, 16'h0500, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(ov4), 16'd0);
    check("mid_rst_data", od4, 16'h0000);
    check("mid_rst_busy", 16'(busy4), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t = '{16'h0200, 16'h8080, 16'h0040, 16'h0000};
    run_neuron(16'h0100, t, 0, 0, "after_rst", got);
    check("after_rst_const", got, 16'h02C0);

    // Input bubbles must not change the result
    for (int k = 0; k < 3; k++) begin
      run_neuron(16'h0100, t, 3, 2, "gaps", got);
      check("gaps_const", got, 16'h02C0);
    end

    // Random neurons against the model
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 4; i++) t[i] = rnd_sm();
      run_neuron(rnd_sm(), t, 2, 3, "rand", got);
    end

    // Single-term configuration
    v1 = 1'b1; b1 = 16'h0080; d1 = 16'h0080;
    check("n1_ready", 16'(rdy1), 16'd1);
    @(negedge clk);
    v1 = 1'b0;
    check("n1_valid", 16'(ov1), 16'd1);
    check("n1_data", od1, 16'h0100);
    check("n1_ready_low", 16'(rdy1), 16'd0);
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    check("n1_drop", 16'(ov1), 16'd0);
    for (int k = 0; k < 5; k++) begin
      bb = rnd_sm();
      v1 = 1'b1; b1 = bb; d1 = rnd_sm();
      got = ref_out(sm2i(bb) + sm2i(d1));
      @(negedge clk);
      v1 = 1'b0;
      check("n1_rand_valid", 16'(ov1), 16'd1);
      check("n1_rand_data", od1, got);
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
